// File: rtl/riscvboy_dmem_resp_pkg.sv
// Shared constants for the riscvBoy data-memory responder: MMIO register offsets
// within the 32-byte page and the CON_STAT bit layout.
package riscvboy_dmem_pkg;

  localparam logic [4:0] CON_TX   = 5'h00;
  localparam logic [4:0] CON_STAT = 5'h04;
  localparam logic [4:0] MTIME_LO = 5'h08;
  localparam logic [4:0] MTIME_HI = 5'h0C;
  localparam logic [4:0] HALT     = 5'h10;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 3;

endpackage

// File: rtl/riscvboy_dmem_resp_if.sv
// Core data port: the core drives requests (master), the responder answers (slave).
interface riscvboy_dmem_resp_if;
  logic        i_mem_wen;
  logic [3:0]  i_mem_wbe;
  logic        i_mem_ren;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;

  modport master (
    output i_mem_wen, i_mem_wbe, i_mem_ren, i_mem_addr, i_mem_wdata,
    input  o_mem_rdata
  );

  modport slave (
    input  i_mem_wen, i_mem_wbe, i_mem_ren, i_mem_addr, i_mem_wdata,
    output o_mem_rdata
  );
endinterface

// File: rtl/riscvboy_dmem_resp_fifo.sv
// Synchronous circular FIFO with wrap-bit pointers; a push is accepted when full
// as long as a pop frees a slot in the same cycle.
module riscvboy_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  // Head reads as zero when empty so the output is clean out of reset.
  assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/riscvboy_dmem_resp.sv
// Zero-wait-state data-memory responder: byte-addressable RAM plus an MMIO page with
// console FIFO, 64-bit cycle timer and halt register.
module riscvboy_dmem_resp
  import riscvboy_dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int unsigned CON_DEPTH = 4
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys_n,
  riscvboy_dmem_resp_if.slave  mem,
  output logic                 o_con_valid,
  output logic [7:0]           o_con_data,
  input  logic                 i_con_ready,
  output logic                 o_halt,
  output logic [31:0]          o_halt_code,
  output logic                 o_bus_err
);

  localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
  localparam int unsigned CON_AW  = $clog2(CON_DEPTH);
  localparam logic [32:0] RAM_WIN = 33'(RAM_WORDS) << 2;

  logic [31:0]       ram_off;
  logic              ram_hit, mmio_hit, unmapped;
  logic [RAM_AW-1:0] ram_idx;
  logic [4:0]        reg_off;
  logic              mmio_wr, mmio_rd;
  logic              wr_con_tx, wr_con_stat, wr_mt_lo, wr_mt_hi, wr_halt, rd_mt_lo;
  logic              unused_bits;

  assign ram_off  = mem.i_mem_addr - RAM_BASE;
  assign ram_hit  = {1'b0, ram_off} < RAM_WIN;
  assign ram_idx  = ram_off[RAM_AW+1:2];
  assign mmio_hit = !ram_hit && (mem.i_mem_addr[31:5] == MMIO_BASE[31:5]);
  assign unmapped = !ram_hit && !mmio_hit;
  assign reg_off  = {mem.i_mem_addr[4:2], 2'b00};
  assign unused_bits = ^{mem.i_mem_addr[1:0], ram_off};

  assign mmio_wr     = mem.i_mem_wen && mmio_hit;
  assign mmio_rd     = mem.i_mem_ren && mmio_hit;
  assign wr_con_tx   = mmio_wr && (reg_off == CON_TX) && mem.i_mem_wbe[0];
  assign wr_con_stat = mmio_wr && (reg_off == CON_STAT) && mem.i_mem_wbe[0];
  assign wr_mt_lo    = mmio_wr && (reg_off == MTIME_LO) && (&mem.i_mem_wbe);
  assign wr_mt_hi    = mmio_wr && (reg_off == MTIME_HI) && (&mem.i_mem_wbe);
  assign wr_halt     = mmio_wr && (reg_off == HALT);
  assign rd_mt_lo    = mmio_rd && (reg_off == MTIME_LO);

  // Data RAM: not reset, lane-masked writes.
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk_sys) begin
    for (int b = 0; b < 4; b++) begin
      if (mem.i_mem_wen && ram_hit && mem.i_mem_wbe[b]) begin
        ram_q[ram_idx][8*b +: 8] <= mem.i_mem_wdata[8*b +: 8];
      end
    end
  end

  // Console FIFO
  logic              con_pop, con_full, con_empty;
  logic [CON_AW:0]   con_count;
  logic [31:0]       con_stat;

  assign o_con_valid = !con_empty;
  assign con_pop     = o_con_valid && i_con_ready;

  riscvboy_sync_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (rst_sys_n),
    .push_i  (wr_con_tx),
    .data_i  (mem.i_mem_wdata[7:0]),
    .pop_i   (con_pop),
    .data_o  (o_con_data),
    .full_o  (con_full),
    .empty_o (con_empty),
    .count_o (con_count)
  );

  logic        ovf_q, ovf_d;
  logic [63:0] mtime_q, mtime_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        halt_q, halt_d;
  logic [31:0] halt_code_q, halt_code_d;
  logic        bus_err_q, bus_err_d;

  assign con_stat = {26'b0, 3'(con_count), ovf_q, con_empty, con_full};

  always_comb begin
    ovf_d = ovf_q;
    // A push into a full FIFO is only lost if no pop frees a slot that cycle.
    if (wr_con_tx && con_full && !con_pop) begin
      ovf_d = 1'b1;
    end else if (wr_con_stat && mem.i_mem_wdata[STAT_OVF]) begin
      ovf_d = 1'b0;
    end

    if (wr_mt_lo) begin
      mtime_d = {mtime_q[63:32], mem.i_mem_wdata};
    end else if (wr_mt_hi) begin
      mtime_d = {mem.i_mem_wdata, mtime_q[31:0]};
    end else begin
      mtime_d = mtime_q + 64'd1;
    end

    hi_shadow_d = rd_mt_lo ? mtime_q[63:32] : hi_shadow_q;
    halt_d      = halt_q | wr_halt;
    halt_code_d = wr_halt ? mem.i_mem_wdata : halt_code_q;
    bus_err_d   = (mem.i_mem_wen || mem.i_mem_ren) && unmapped;
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      ovf_q       <= 1'b0;
      mtime_q     <= '0;
      hi_shadow_q <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      ovf_q       <= ovf_d;
      mtime_q     <= mtime_d;
      hi_shadow_q <= hi_shadow_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Reads see pre-edge state, which gives read-before-write for free.
  always_comb begin
    mem.o_mem_rdata = '0;
    if (mem.i_mem_ren) begin
      if (ram_hit) begin
        mem.o_mem_rdata = ram_q[ram_idx];
      end else if (mmio_hit) begin
        case (reg_off)
          CON_STAT: mem.o_mem_rdata = con_stat;
          MTIME_LO: mem.o_mem_rdata = mtime_q[31:0];
          MTIME_HI: mem.o_mem_rdata = hi_shadow_q;
          HALT:     mem.o_mem_rdata = halt_code_q;
          default:  mem.o_mem_rdata = '0;
        endcase
      end
    end
  end

  assign o_halt      = halt_q;
  assign o_halt_code = halt_code_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_riscvboy_dmem_resp.sv
// Directed bench for riscvboy_dmem_resp: RAM lanes, read-before-write, console FIFO,
// mtime and shadow, halt, unmapped access and asynchronous reset.
module tb_riscvboy_dmem_resp;

  localparam logic [31:0] MB = 32'h1000_0000;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        con_valid, con_ready, halt, bus_err;
  logic [7:0]  con_data;
  logic [31:0] halt_code;
  logic [31:0] rv;
  int          n_tests = 0;
  int          n_fail  = 0;

  riscvboy_dmem_resp_if bus ();

  riscvboy_dmem_resp dut (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .mem         (bus.slave),
    .o_con_valid (con_valid),
    .o_con_data  (con_data),
    .i_con_ready (con_ready),
    .o_halt      (halt),
    .o_halt_code (halt_code),
    .o_bus_err   (bus_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wbe);
    bus.i_mem_wen   = 1'b1;
    bus.i_mem_addr  = addr;
    bus.i_mem_wdata = data;
    bus.i_mem_wbe   = wbe;
    @(posedge clk_sys); #1;
    bus.i_mem_wen   = 1'b0;
    bus.i_mem_wbe   = 4'h0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    bus.i_mem_ren  = 1'b1;
    bus.i_mem_addr = addr;
    #2;
    data = bus.o_mem_rdata;
    @(posedge clk_sys); #1;
    bus.i_mem_ren  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk_sys); #1;
  endtask

  initial begin
    rst_sys_n       = 1'b0;
    con_ready       = 1'b0;
    bus.i_mem_wen   = 1'b0;
    bus.i_mem_ren   = 1'b0;
    bus.i_mem_wbe   = 4'h0;
    bus.i_mem_addr  = '0;
    bus.i_mem_wdata = '0;
    idle();
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_halt_code", halt_code, 32'h0);
    check("rst_con_valid", {31'b0, con_valid}, 32'h0);
    check("rst_con_data", {24'b0, con_data}, 32'h0);
    check("rst_bus_err", {31'b0, bus_err}, 32'h0);
    check("rst_rdata_idle", bus.o_mem_rdata, 32'h0);
    rst_sys_n = 1'b1;
    idle();
    rd(MB + 32'h04, rv); check("rst_con_stat", rv, 32'h0000_0002);

    // Byte lanes
    wr(32'h100, 32'hAABB_CCDD, 4'b1111);
    wr(32'h100, 32'h0011_0000, 4'b0100);
    rd(32'h100, rv); check("lane_merge", rv, 32'hAA11_CCDD);
    wr(32'h100, 32'hFFFF_FFFF, 4'b0000);
    check("wbe0_no_err", {31'b0, bus_err}, 32'h0);
    rd(32'h100, rv); check("wbe0_noop", rv, 32'hAA11_CCDD);

    // Read-before-write
    wr(32'h200, 32'h3, 4'b1111);
    bus.i_mem_ren = 1'b1;
    bus.i_mem_wen = 1'b1; bus.i_mem_addr = 32'h200; bus.i_mem_wdata = 32'h5;
    bus.i_mem_wbe = 4'b1111;
    #2; check("rbw_old", bus.o_mem_rdata, 32'h3);
    @(posedge clk_sys); #1;
    bus.i_mem_ren = 1'b0; bus.i_mem_wen = 1'b0; bus.i_mem_wbe = 4'h0;
    rd(32'h200, rv); check("rbw_new", rv, 32'h5);

    // Console overflow and drain
    for (int i = 0; i < 5; i++) wr(MB, 32'h41 + i, 4'b0001);
    rd(MB + 32'h04, rv); check("con_ovf_stat", rv, 32'h0000_0025);
    rd(MB, rv); check("con_tx_reads0", rv, 32'h0);
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("drain_valid", {31'b0, con_valid}, 32'h1);
      check("drain_data", {24'b0, con_data}, 32'h41 + i);
      @(posedge clk_sys); #1;
    end
    con_ready = 1'b0;
    #2; check("drain_empty", {31'b0, con_valid}, 32'h0);
    rd(MB + 32'h04, rv); check("stat_ovf_empty", rv, 32'h0000_0006);
    wr(MB + 32'h04, 32'h4, 4'b0001);
    rd(MB + 32'h04, rv); check("ovf_clear", rv, 32'h0000_0002);

    // Full FIFO: push together with pop
    for (int i = 0; i < 4; i++) wr(MB, 32'h61 + i, 4'b0001);
    rd(MB + 32'h04, rv); check("full_stat", rv, 32'h0000_0021);
    con_ready = 1'b1;
    wr(MB, 32'h65, 4'b0001);
    con_ready = 1'b0;
    rd(MB + 32'h04, rv); check("push_pop_full", rv, 32'h0000_0021);
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2; check("pp_drain", {24'b0, con_data}, 32'h62 + i);
      @(posedge clk_sys); #1;
    end
    con_ready = 1'b0;

    // mtime wrap and hi shadow
    wr(MB + 32'h0C, 32'h0, 4'b1111);
    wr(MB + 32'h08, 32'hFFFF_FFFE, 4'b1111);
    idle();
    rd(MB + 32'h08, rv); check("mt_lo_wrap", rv, 32'hFFFF_FFFF);
    rd(MB + 32'h0C, rv); check("mt_hi_shadow0", rv, 32'h0);
    rd(MB + 32'h08, rv); check("mt_lo_after", rv, 32'h0000_0001);
    rd(MB + 32'h0C, rv); check("mt_hi_shadow1", rv, 32'h1);
    bus.i_mem_ren = 1'b1;
    bus.i_mem_wen = 1'b1; bus.i_mem_addr = MB + 32'h08; bus.i_mem_wdata = 32'h1234;
    bus.i_mem_wbe = 4'b1111;
    #2; check("mt_lo_rbw", bus.o_mem_rdata, 32'h0000_0003);
    @(posedge clk_sys); #1;
    bus.i_mem_ren = 1'b0; bus.i_mem_wen = 1'b0; bus.i_mem_wbe = 4'h0;
    rd(MB + 32'h08, rv); check("mt_lo_loaded", rv, 32'h0000_1234);

    // Halt
    wr(MB + 32'h10, 32'h1, 4'b1111);
    check("halt_set", {31'b0, halt}, 32'h1);
    check("halt_code", halt_code, 32'h1);
    wr(MB + 32'h10, 32'h7, 4'b1111);
    check("halt_sticky", {31'b0, halt}, 32'h1);
    rd(MB + 32'h10, rv); check("halt_rd", rv, 32'h7);

    // Reserved and unmapped
    rd(MB + 32'h14, rv); check("rsvd_rd", rv, 32'h0);
    check("rsvd_no_err", {31'b0, bus_err}, 32'h0);
    rd(32'h2000_0000, rv); check("unmap_rd", rv, 32'h0);
    check("bus_err_pulse", {31'b0, bus_err}, 32'h1);
    idle();
    check("bus_err_clear", {31'b0, bus_err}, 32'h0);

    // Mid-operation asynchronous reset
    wr(MB, 32'h99, 4'b0001);
    check("pre_rst_valid", {31'b0, con_valid}, 32'h1);
    rst_sys_n = 1'b0;
    #1;
    check("arst_halt", {31'b0, halt}, 32'h0);
    check("arst_halt_code", halt_code, 32'h0);
    check("arst_con_valid", {31'b0, con_valid}, 32'h0);
    check("arst_con_data", {24'b0, con_data}, 32'h0);
    idle();
    rst_sys_n = 1'b1;
    rd(MB + 32'h04, rv); check("arst_con_stat", rv, 32'h0000_0002);
    rd(32'h100, rv); check("ram_kept", rv, 32'hAA11_CCDD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
